// File: rtl/shared_bank_arbiter_if.sv
// Core-side bus of one shared memory bank: per-core request levels, addresses,
// write data, and the registered read data / completion pulses / busy flag.
interface shared_bank_arbiter_if #(
   parameter int N_CORES = 16,
   parameter int BANK_W  = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
);
   logic [N_CORES-1:0]                 read;
   logic [N_CORES-1:0]                 write;
   logic [N_CORES*(BANK_W+ADDR_W)-1:0] addr_in;
   logic [N_CORES*DATA_W-1:0]          data_in;
   logic [N_CORES*DATA_W-1:0]          data_out;
   logic [N_CORES-1:0]                 finish;
   logic                               busy;

   modport master (
      output read, write, addr_in, data_in,
      input  data_out, finish, busy
   );

   modport slave (
      input  read, write, addr_in, data_in,
      output data_out, finish, busy
   );
endinterface

// File: rtl/shared_bank_arbiter.sv
// One memory bank shared by N_CORES cores: round-robin grant in IDLE, single
// memory access in ACCESS, one-cycle finish pulse in RESP (one access per 3 cycles).
module shared_bank_arbiter #(
   parameter int N_CORES = 16,
   parameter int BANK_W  = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 256,
   parameter int BANK_ID = 0
) (
   input  logic                   clock,
   input  logic                   reset_n,
   shared_bank_arbiter_if.slave   bus
);
   localparam int SLICE_W = BANK_W + ADDR_W;
   localparam int IDX_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]                state_q, state_d;
   logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      op_q, op_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic [DATA_W-1:0]         wdata_q, wdata_d;
   logic [N_CORES-1:0]        finish_q, finish_d;
   logic [N_CORES*DATA_W-1:0] data_out_q, data_out_d;

   logic [DATA_W-1:0]         mem [DEPTH];

   logic [N_CORES-1:0]        elig;
   logic                      grant_vld;
   logic [IDX_W-1:0]          grant_idx;
   logic                      in_range;

   always_comb begin
      for (int i = 0; i < N_CORES; i++) begin
         elig[i] = (bus.read[i] | bus.write[i]) &&
                   (bus.addr_in[i*SLICE_W+ADDR_W +: BANK_W] == BANK_W'(BANK_ID));
      end
   end

   // First eligible core at or above rr_ptr, wrapping past the top index.
   always_comb begin
      int c;
      c         = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N_CORES; k++) begin
         c = int'(rr_ptr_q) + k;
         if (c >= N_CORES) c = c - N_CORES;
         if (!grant_vld && elig[c]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(c);
         end
      end
   end

   assign in_range = (32'(addr_q) < DEPTH);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      idx_d      = idx_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      finish_d   = '0;
      data_out_d = data_out_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               idx_d   = grant_idx;
               op_d    = bus.write[grant_idx];
               addr_d  = bus.addr_in[grant_idx*SLICE_W +: ADDR_W];
               wdata_d = bus.data_in[grant_idx*DATA_W +: DATA_W];
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // Out-of-range reads return zero rather than whatever the array yields.
            if (!op_q) begin
               data_out_d[idx_q*DATA_W +: DATA_W] = in_range ? mem[addr_q] : '0;
            end
            finish_d[idx_q] = 1'b1;
            state_d         = RESP;
         end
         RESP: begin
            rr_ptr_d = (idx_q == IDX_W'(N_CORES-1)) ? '0 : idx_q + IDX_W'(1);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         idx_q      <= '0;
         op_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         finish_q   <= '0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         idx_q      <= idx_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         finish_q   <= finish_d;
         data_out_q <= data_out_d;
      end
   end

   // Reset forces state_q to IDLE asynchronously, so an aborted ACCESS never commits.
   always_ff @(posedge clock) begin
      if (state_q == ACCESS && op_q && in_range) begin
         mem[addr_q] <= wdata_q;
      end
   end

   assign bus.finish   = finish_q;
   assign bus.data_out = data_out_q;
   assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_shared_bank_arbiter.sv
// Directed bench for shared_bank_arbiter (16 cores, DEPTH=200, BANK_ID=2).
module tb_shared_bank_arbiter;
   localparam int N     = 16;
   localparam int BW    = 4;
   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int DEPTH = 200;
   localparam int BID   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   shared_bank_arbiter_if #(.N_CORES(N), .BANK_W(BW), .ADDR_W(AW), .DATA_W(DW)) bus ();

   shared_bank_arbiter #(
      .N_CORES(N), .BANK_W(BW), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .BANK_ID(BID)
   ) dut (
      .clock  (clk),
      .reset_n(rst_n),
      .bus    (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int c, input bit rd, input bit wr, input int bank,
                          input int word, input logic [7:0] d);
      bus.read[c]  = rd;
      bus.write[c] = wr;
      bus.addr_in[c*(BW+AW) +: (BW+AW)] = {4'(bank), 8'(word)};
      bus.data_in[c*DW +: DW] = d;
   endtask

   task automatic clr_req(input int c);
      bus.read[c]  = 1'b0;
      bus.write[c] = 1'b0;
   endtask

   // Steps edge by edge until finish is non-zero; cyc=0 and f=0 if it never arrives.
   task automatic wait_finish(output logic [15:0] f, output int cyc);
      f   = '0;
      cyc = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.finish != 0) begin
            f   = bus.finish;
            cyc = k;
            break;
         end
      end
   endtask

   task automatic access(input string tag, input int c, input bit rd, input bit wr,
                         input int word, input logic [7:0] d);
      logic [15:0] f;
      int cyc;
      set_req(c, rd, wr, BID, word, d);
      wait_finish(f, cyc);
      check({tag, "_finish"}, 128'(f), 128'(16'h1 << c));
      check({tag, "_lat"}, 128'(cyc), 128'(2));
      check({tag, "_busy"}, 128'(bus.busy), 128'(1));
      clr_req(c);
      @(posedge clk); #1;
      check({tag, "_fin_drop"}, 128'(bus.finish), 128'(0));
   endtask

   logic [15:0] f;
   int          cyc;
   logic        saw_busy, saw_fin;
   logic [15:0] exp_order [3];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.read    = '0;
      bus.write   = '0;
      bus.addr_in = '0;
      bus.data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_finish", 128'(bus.finish), 128'(0));
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_data_out", 128'(bus.data_out), 128'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Core 3 write then read of word 0x10
      access("wr3", 3, 1'b0, 1'b1, 'h10, 8'hA5);
      access("rd3", 3, 1'b1, 1'b0, 'h10, 8'h00);
      check("rd3_data", 128'(bus.data_out[31:24]), 128'(8'hA5));

      // Core 2 targets another bank: never granted
      set_req(2, 1'b1, 1'b0, BID + 1, 0, 8'h00);
      saw_busy = 1'b0;
      saw_fin  = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         saw_busy |= bus.busy;
         saw_fin  |= (bus.finish != 0);
      end
      check("other_bank_busy", 128'(saw_busy), 128'(0));
      check("other_bank_finish", 128'(saw_fin), 128'(0));
      clr_req(2);

      // Core 7 with read and write both high performs a write
      access("rw7", 7, 1'b1, 1'b1, 4, 8'h3C);
      access("rd7", 7, 1'b1, 1'b0, 4, 8'h00);
      check("rd7_data", 128'(bus.data_out[63:56]), 128'(8'h3C));
      check("hold3_data", 128'(bus.data_out[31:24]), 128'(8'hA5));

      // Top in-range word and out-of-range word (DEPTH=200)
      access("w199", 9, 1'b0, 1'b1, 199, 8'h5A);
      access("w0", 9, 1'b0, 1'b1, 0, 8'h11);
      access("rd199", 9, 1'b1, 1'b0, 199, 8'h00);
      check("rd199_data", 128'(bus.data_out[79:72]), 128'(8'h5A));
      access("w200", 9, 1'b0, 1'b1, 200, 8'hEE);
      access("rd200", 9, 1'b1, 1'b0, 200, 8'h00);
      check("rd200_data", 128'(bus.data_out[79:72]), 128'(8'h00));
      access("rd199b", 9, 1'b1, 1'b0, 199, 8'h00);
      check("rd199b_data", 128'(bus.data_out[79:72]), 128'(8'h5A));
      access("rd0", 9, 1'b1, 1'b0, 0, 8'h00);
      check("rd0_data", 128'(bus.data_out[79:72]), 128'(8'h11));
      access("rd4", 9, 1'b1, 1'b0, 4, 8'h00);
      check("rd4_data", 128'(bus.data_out[79:72]), 128'(8'h3C));
      access("rd10", 9, 1'b1, 1'b0, 'h10, 8'h00);
      check("rd10_data", 128'(bus.data_out[79:72]), 128'(8'hA5));

      // Reset asserted while core 5's write is in RESP (rr_ptr was 10)
      set_req(5, 1'b0, 1'b1, BID, 'h20, 8'h99);
      wait_finish(f, cyc);
      check("w5_finish", 128'(f), 128'(16'h0020));
      rst_n = 1'b0;
      #1;
      check("mid_rst_finish", 128'(bus.finish), 128'(0));
      check("mid_rst_busy", 128'(bus.busy), 128'(0));
      check("mid_rst_data_out", 128'(bus.data_out), 128'(0));
      clr_req(5);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      // rr_ptr=0 grants 1 before 12
      set_req(1, 1'b1, 1'b0, BID, 0, 8'h00);
      set_req(12, 1'b1, 1'b0, BID, 0, 8'h00);
      wait_finish(f, cyc);
      check("post_rst_first", 128'(f), 128'(16'h0002));
      clr_req(1);
      wait_finish(f, cyc);
      check("post_rst_second", 128'(f), 128'(16'h1000));
      clr_req(12);
      @(posedge clk); #1;
      access("rd5", 5, 1'b1, 1'b0, 'h20, 8'h00);
      check("rd5_data", 128'(bus.data_out[47:40]), 128'(8'h99));

      // Round-robin from rr_ptr=0 with cores 0, 5, 15
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      exp_order[0] = 16'h0001;
      exp_order[1] = 16'h0020;
      exp_order[2] = 16'h8000;
      set_req(0, 1'b1, 1'b0, BID, 1, 8'h00);
      set_req(5, 1'b1, 1'b0, BID, 1, 8'h00);
      set_req(15, 1'b1, 1'b0, BID, 1, 8'h00);
      for (int j = 0; j < 3; j++) begin
         wait_finish(f, cyc);
         check($sformatf("rr_grant%0d", j), 128'(f), 128'(exp_order[j]));
         for (int b = 0; b < N; b++) if (f[b]) clr_req(b);
      end
      // Cores 0 and 15 again: 0 first, then 15 (5 not requesting)
      set_req(0, 1'b1, 1'b0, BID, 1, 8'h00);
      set_req(15, 1'b1, 1'b0, BID, 1, 8'h00);
      wait_finish(f, cyc);
      check("rr2_first", 128'(f), 128'(16'h0001));
      for (int b = 0; b < N; b++) if (f[b]) clr_req(b);
      wait_finish(f, cyc);
      check("rr2_second", 128'(f), 128'(16'h8000));
      for (int b = 0; b < N; b++) if (f[b]) clr_req(b);
      clr_req(0);
      clr_req(15);
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
